adder_pipelined_param: RTL

Parametrised, pipelined two's-complement adder/subtractor: the next generation of the team's fixed 4-bit adder variants. The WIDTH-bit operation is split into SLICES equal carry-chained slices, one slice per pipeline stage, so throughput stays at one result per clock at any width. The block has valid/ready handshakes on both sides and per-transaction add/subtract mode. It produces carry/borrow and signed-overflow flags, and sits between operand sources (counters, register files) and result consumers in the arithmetic datapath.

---
 rtl/adder_pipelined_param_pkg.sv | 18 +
 rtl/adder_slice.sv | 14 +
 rtl/adder_pipelined_param.sv | 116 +++++++++++
 3 files changed

// File: rtl/adder_pipelined_param_pkg.sv
// Shared definitions for the pipelined adder/subtractor: operation mode encoding
// and the slice-width helper used to validate the WIDTH/SLICES split.
package adder_pipelined_param_pkg;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

  // Slice width for a legal split, 0 when WIDTH/SLICES cannot be divided evenly.
  function automatic int calc_sw(input int width, input int slices);
    int sw;
    if (width < 2 || slices < 1 || slices > width || (width % slices) != 0) sw = 0;
    else sw = width / slices;
    return sw;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational SW-bit ripple slice; one instance per pipeline stage.
module adder_slice #(
  parameter int SW = 4
) (
  input  logic [SW-1:0] a_s,
  input  logic [SW-1:0] b_s,
  input  logic          ci,
  output logic [SW-1:0] s,
  output logic          co
);

  assign {co, s} = {1'b0, a_s} + {1'b0, b_s} + {{SW{1'b0}}, ci};

endmodule

// File: rtl/adder_pipelined_param.sv
// Pipelined WIDTH-bit adder/subtractor, one carry-chained slice per stage, with
// valid/ready on both sides and a single global advance enable (no bubble collapse).
module adder_pipelined_param
  import adder_pipelined_param_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int SLICES = 4
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SW = calc_sw(WIDTH, SLICES);

  if (SW == 0) begin : g_bad_cfg
    $error("adder_pipelined_param: WIDTH must be >= 2 and divisible by SLICES");
  end

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic             ovf_nxt;
  logic             ovf_q;

  // Per-stage registers: valid, slice carry, skewed operands, de-skewed sum bits.
  logic             v_q   [SLICES];
  logic             c_q   [SLICES];
  logic [WIDTH-1:0] a_sk  [SLICES];
  logic [WIDTH-1:0] b_sk  [SLICES];
  logic [WIDTH-1:0] s_dk  [SLICES];

  logic [WIDTH-1:0] st_a  [SLICES];
  logic [WIDTH-1:0] st_b  [SLICES];
  logic [WIDTH-1:0] st_lo [SLICES];
  logic [WIDTH-1:0] s_nxt [SLICES];
  logic             st_c  [SLICES];
  logic [SW-1:0]    s_slc [SLICES];
  logic             co_slc[SLICES];

  assign adv      = !v_q[SLICES-1] || out_ready;
  assign in_ready = adv;

  // Subtraction as A + ~B + ~cin, so cin doubles as borrow-in.
  assign b_eff = (sub == MODE_SUB) ? ~b : b;
  assign c0    = (sub == MODE_SUB) ? ~cin : cin;

  for (genvar k = 0; k < SLICES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign st_a[k]  = a;
      assign st_b[k]  = b_eff;
      assign st_c[k]  = c0;
      assign st_lo[k] = '0;
    end else begin : g_body
      assign st_a[k]  = a_sk[k-1];
      assign st_b[k]  = b_sk[k-1];
      assign st_c[k]  = c_q[k-1];
      assign st_lo[k] = s_dk[k-1];
    end

    adder_slice #(.SW(SW)) u_slice (
      .a_s (st_a[k][k*SW +: SW]),
      .b_s (st_b[k][k*SW +: SW]),
      .ci  (st_c[k]),
      .s   (s_slc[k]),
      .co  (co_slc[k])
    );

    // Bits above the slices added so far are always zero, so OR-in is a clean insert.
    assign s_nxt[k] = st_lo[k] | (WIDTH'(s_slc[k]) << (k*SW));
  end

  assign ovf_nxt = (st_a[SLICES-1][WIDTH-1] == st_b[SLICES-1][WIDTH-1]) &&
                   (s_slc[SLICES-1][SW-1] != st_a[SLICES-1][WIDTH-1]);

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      for (int k = 0; k < SLICES; k++) begin
        v_q[k]  <= 1'b0;
        c_q[k]  <= 1'b0;
        a_sk[k] <= '0;
        b_sk[k] <= '0;
        s_dk[k] <= '0;
      end
      ovf_q <= 1'b0;
    end else if (adv) begin
      v_q[0] <= in_valid;
      for (int k = 1; k < SLICES; k++) begin
        v_q[k] <= v_q[k-1];
      end
      for (int k = 0; k < SLICES; k++) begin
        c_q[k]  <= co_slc[k];
        a_sk[k] <= st_a[k];
        b_sk[k] <= st_b[k];
        s_dk[k] <= s_nxt[k];
      end
      ovf_q <= ovf_nxt;
    end
  end

  assign out_valid = v_q[SLICES-1];
  assign sum       = s_dk[SLICES-1];
  assign cout      = c_q[SLICES-1];
  assign ovf       = ovf_q;

endmodule
